// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver (5..9 data bits, optional parity, 1-2 stop bits)
// with a one-deep acknowledged output register and a sticky overrun flag.
module uart_rx_os #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned OS_RATE   = 16,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 os_tick,
   input  logic                 rx,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);

   localparam int unsigned CNT_W = $clog2(OS_RATE);
   localparam int unsigned IDX_W = 4;
   localparam int unsigned HALF  = OS_RATE / 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic                 r_rx_meta;
   logic                 r_rx_s;
   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_en;
   logic                 r_par_odd;
   logic                 r_par_bad;
   logic                 r_stop_bad;
   logic                 r_need_high;
   logic                 r_cmp;
   logic                 r_cmp_ferr;
   logic                 r_cmp_perr;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_busy;
   logic                 r_frame_err;
   logic                 r_parity_err;
   logic                 r_overrun;

   state_t               w_state_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_par_en_nxt;
   logic                 w_par_odd_nxt;
   logic                 w_par_bad_nxt;
   logic                 w_stop_bad_nxt;
   logic                 w_need_high_nxt;
   logic                 w_done;
   logic                 w_cnt_end;
   logic                 w_cnt_half;

   assign w_cnt_end  = (r_cnt == CNT_W'(OS_RATE - 1));
   assign w_cnt_half = (r_cnt == CNT_W'(HALF - 1));

   // Two-flop synchronizer for the asynchronous serial line
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_idx_nxt       = r_idx;
      w_shift_nxt     = r_shift;
      w_par_en_nxt    = r_par_en;
      w_par_odd_nxt   = r_par_odd;
      w_par_bad_nxt   = r_par_bad;
      w_stop_bad_nxt  = r_stop_bad;
      w_need_high_nxt = r_need_high;
      w_done          = 1'b0;
      case (r_state)
         S_IDLE: begin
            // After a frame error the line must be seen idle before re-arming
            if (r_rx_s) begin
               w_need_high_nxt = 1'b0;
            end
            if (os_tick && !r_rx_s && !r_need_high) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = '0;
            end
         end
         S_START: begin
            if (os_tick) begin
               if (w_cnt_half) begin
                  if (!r_rx_s) begin
                     w_state_nxt    = S_DATA;
                     w_cnt_nxt      = '0;
                     w_idx_nxt      = '0;
                     w_par_en_nxt   = parity_en;
                     w_par_odd_nxt  = parity_odd;
                     w_par_bad_nxt  = 1'b0;
                     w_stop_bad_nxt = 1'b0;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         S_DATA: begin
            if (os_tick) begin
               if (w_cnt_end) begin
                  w_cnt_nxt   = '0;
                  w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
                  if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                     w_idx_nxt   = '0;
                     w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                  end else begin
                     w_idx_nxt = r_idx + IDX_W'(1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (os_tick) begin
               if (w_cnt_end) begin
                  w_cnt_nxt     = '0;
                  w_par_bad_nxt = (r_rx_s != ((^r_shift) ^ r_par_odd));
                  w_state_nxt   = S_STOP;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         S_STOP: begin
            if (os_tick) begin
               if (w_cnt_end) begin
                  w_cnt_nxt      = '0;
                  w_stop_bad_nxt = r_stop_bad | ~r_rx_s;
                  if (r_idx == IDX_W'(STOP_BITS - 1)) begin
                     w_idx_nxt       = '0;
                     w_done          = 1'b1;
                     w_need_high_nxt = w_stop_bad_nxt;
                     w_state_nxt     = S_IDLE;
                  end else begin
                     w_idx_nxt = r_idx + IDX_W'(1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_par_en    <= 1'b0;
         r_par_odd   <= 1'b0;
         r_par_bad   <= 1'b0;
         r_stop_bad  <= 1'b0;
         r_need_high <= 1'b0;
         r_cmp       <= 1'b0;
         r_cmp_ferr  <= 1'b0;
         r_cmp_perr  <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_par_en    <= w_par_en_nxt;
         r_par_odd   <= w_par_odd_nxt;
         r_par_bad   <= w_par_bad_nxt;
         r_stop_bad  <= w_stop_bad_nxt;
         r_need_high <= w_need_high_nxt;
         r_cmp       <= w_done;
         r_cmp_ferr  <= w_stop_bad_nxt;
         r_cmp_perr  <= r_par_bad;
      end
   end

   // Result stage: applies the completed frame one clk after the last stop sample
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_busy       <= (w_state_nxt != S_IDLE);
         r_frame_err  <= r_cmp & r_cmp_ferr;
         r_parity_err <= r_cmp & r_cmp_perr;
         if (r_cmp && !r_cmp_ferr && !r_cmp_perr) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !rx_ack) begin
               r_overrun <= 1'b1;
            end
         end else if (rx_ack) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign busy       = r_busy;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed plus randomized frames against a frame-level reference model;
// a second instance covers the 7-bit, 2-stop-bit, 8x oversampling configuration.
module tb_uart_rx_os;

   logic       clk = 1'b0;
   logic       reset, os_tick, rx, parity_en, parity_odd, rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid, busy, frame_err, parity_err, overrun;
   logic [6:0] rx_data7;
   logic       rx_valid7, busy7, frame_err7, parity_err7, overrun7;

   always #5 clk = ~clk;

   uart_rx_os dut (
      .clk(clk), .reset(reset), .os_tick(os_tick), .rx(rx),
      .parity_en(parity_en), .parity_odd(parity_odd), .rx_ack(rx_ack),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
   );

   uart_rx_os #(.DATA_BITS(7), .OS_RATE(8), .STOP_BITS(2)) dut7 (
      .clk(clk), .reset(reset), .os_tick(os_tick), .rx(rx),
      .parity_en(parity_en), .parity_odd(parity_odd), .rx_ack(rx_ack),
      .rx_data(rx_data7), .rx_valid(rx_valid7), .busy(busy7),
      .frame_err(frame_err7), .parity_err(parity_err7), .overrun(overrun7)
   );

   int n_checks = 0;
   int n_err    = 0;
   int fe_cnt = 0, pe_cnt = 0, fe7_cnt = 0, pe7_cnt = 0;

   // Reference model state for the default instance
   logic [7:0] m_data;
   bit         m_valid, m_ovr;
   bit         ack_on_done, ack_fired, seen_busy;

   // Count high cycles of each error flag
   always @(negedge clk) begin
      if (frame_err)   fe_cnt  = fe_cnt + 1;
      if (parity_err)  pe_cnt  = pe_cnt + 1;
      if (frame_err7)  fe7_cnt = fe7_cnt + 1;
      if (parity_err7) pe7_cnt = pe7_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit calc_par(input logic [8:0] d, input int nbits, input bit odd);
      bit p = odd;
      for (int i = 0; i < nbits; i++) p = p ^ d[i];
      return p;
   endfunction

   // One clock step; optionally acknowledges in the cycle right after busy falls
   task automatic step();
      @(negedge clk);
      rx_ack = 1'b0;
      if (ack_on_done && !ack_fired && seen_busy && !busy) begin
         rx_ack    = 1'b1;
         ack_fired = 1'b1;
      end
      if (busy) seen_busy = 1'b1;
   endtask

   task automatic send_bit(input logic v, input int n);
      for (int k = 0; k < n; k++) begin
         step();
         rx      = v;
         os_tick = 1'b1;
         step();
         os_tick = 1'b0;
         step();
      end
   endtask

   task automatic send_frame(input logic [8:0] d, input int nbits, input int os, input bit pen,
                             input bit pbit, input bit s1, input bit s2, input int nstop,
                             input bit scramble);
      send_bit(1'b0, os);
      if (scramble) begin
         parity_en  = 1'($urandom);
         parity_odd = 1'($urandom);
      end
      for (int i = 0; i < nbits; i++) send_bit(d[i], os);
      if (pen) send_bit(pbit, os);
      send_bit(s1, os);
      if (nstop == 2) send_bit(s2, os);
      send_bit(1'b1, 2 * os);
   endtask

   task automatic apply_reset();
      step();
      reset = 1'b1;
      rx    = 1'b1;
      step();
      step();
      reset   = 1'b0;
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic do_ack();
      step();
      rx_ack = 1'b1;
      step();
      m_valid = 1'b0;
   endtask

   // Frame on the default instance; model predicts result from the spec rules
   task automatic run_frame(input string tag, input logic [7:0] d, input bit pen, input bit podd,
                            input bit pbit, input bit stop, input bit ack_done, input bit scramble);
      int  fe0, pe0;
      bit  perr, ferr, good;
      parity_en   = pen;
      parity_odd  = podd;
      fe0         = fe_cnt;
      pe0         = pe_cnt;
      ack_on_done = ack_done;
      ack_fired   = 1'b0;
      seen_busy   = 1'b0;
      send_frame({1'b0, d}, 8, 16, pen, pbit, stop, 1'b1, 1, scramble);
      ack_on_done = 1'b0;
      perr = pen && (pbit != calc_par({1'b0, d}, 8, podd));
      ferr = !stop;
      good = !perr && !ferr;
      if (good) begin
         if (m_valid && !ack_fired) m_ovr = 1'b1;
         m_data  = d;
         m_valid = 1'b1;
      end else if (ack_fired) begin
         m_valid = 1'b0;
      end
      check_eq({tag, ".data"},  32'(rx_data), 32'(m_data));
      check_eq({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
      check_eq({tag, ".ovr"},   32'(overrun), 32'(m_ovr));
      check_eq({tag, ".ferr"},  32'(fe_cnt - fe0), 32'(ferr));
      check_eq({tag, ".perr"},  32'(pe_cnt - pe0), 32'(perr));
      check_eq({tag, ".busy"},  32'(busy), 32'd0);
   endtask

   initial begin
      int         fe0, pe0;
      logic [7:0] d;
      bit         pen, podd, pbit, stop;
      reset       = 1'b1;
      os_tick     = 1'b0;
      rx          = 1'b1;
      parity_en   = 1'b0;
      parity_odd  = 1'b0;
      rx_ack      = 1'b0;
      ack_on_done = 1'b0;
      ack_fired   = 1'b0;
      seen_busy   = 1'b0;

      apply_reset();
      check_eq("rst.data",  32'(rx_data), 32'h0);
      check_eq("rst.valid", 32'(rx_valid), 32'h0);
      check_eq("rst.busy",  32'(busy), 32'h0);
      check_eq("rst.ovr",   32'(overrun), 32'h0);
      check_eq("rst.busy7", 32'(busy7), 32'h0);

      // Start-bit glitch is rejected silently
      fe0 = fe_cnt;
      pe0 = pe_cnt;
      send_bit(1'b0, 3);
      check_eq("glitch.busy_hi", 32'(busy), 32'h1);
      send_bit(1'b1, 20);
      check_eq("glitch.busy_lo", 32'(busy), 32'h0);
      check_eq("glitch.valid",   32'(rx_valid), 32'h0);
      check_eq("glitch.flags",   32'((fe_cnt - fe0) + (pe_cnt - pe0)), 32'h0);

      run_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_ack();
      check_eq("ack.valid", 32'(rx_valid), 32'h0);

      run_frame("par_bad",  8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_frame("par_good", 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      do_ack();

      run_frame("stop_bad", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame("after_fe", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      apply_reset();
      run_frame("ovr1", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_frame("ovr2", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_ack();
      check_eq("ovr.sticky", 32'(overrun), 32'h1);
      apply_reset();
      check_eq("ovr.reset", 32'(overrun), 32'h0);
      run_frame("ack1", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_frame("ack2", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Randomized frames; parity config is scrambled after the start bit
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         pen  = 1'($urandom);
         podd = 1'($urandom);
         pbit = calc_par({1'b0, d}, 8, podd) ^ ($urandom_range(0, 4) == 0);
         stop = ($urandom_range(0, 5) != 0);
         run_frame($sformatf("rnd%0d", n), d, pen, podd, pbit, stop,
                   1'($urandom_range(0, 3) == 0), 1'b1);
         if ($urandom_range(0, 1) == 1) do_ack();
      end

      // 7-bit, 2 stop bits, 8x oversampling instance
      apply_reset();
      parity_en = 1'b0;
      fe0 = fe7_cnt;
      pe0 = pe7_cnt;
      send_frame(9'h02B, 7, 8, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0);
      check_eq("d7.good.data",  32'(rx_data7), 32'h2B);
      check_eq("d7.good.valid", 32'(rx_valid7), 32'h1);
      check_eq("d7.good.flags", 32'((fe7_cnt - fe0) + (pe7_cnt - pe0)), 32'h0);
      fe0 = fe7_cnt;
      send_frame(9'h05A, 7, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0);
      check_eq("d7.stop2.ferr", 32'(fe7_cnt - fe0), 32'h1);
      check_eq("d7.stop2.data", 32'(rx_data7), 32'h2B);
      check_eq("d7.stop2.ovr",  32'(overrun7), 32'h0);

      fe0 = fe7_cnt;
      pe0 = pe7_cnt;
      send_bit(1'b0, 8);
      send_bit(1'b0, 8);
      send_bit(1'b1, 8);
      check_eq("d7.mid.busy", 32'(busy7), 32'h1);
      step();
      reset = 1'b1;
      rx    = 1'b1;
      step();
      reset = 1'b0;
      check_eq("d7.rst.data",  32'(rx_data7), 32'h0);
      check_eq("d7.rst.valid", 32'(rx_valid7), 32'h0);
      check_eq("d7.rst.busy",  32'(busy7), 32'h0);
      check_eq("d7.rst.ovr",   32'(overrun7), 32'h0);
      send_bit(1'b1, 40);
      check_eq("d7.idle.busy",  32'(busy7), 32'h0);
      check_eq("d7.idle.valid", 32'(rx_valid7), 32'h0);
      check_eq("d7.idle.flags", 32'((fe7_cnt - fe0) + (pe7_cnt - pe0)), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter OS_RATE, default 16, os_tick pulses per bit period; legal values 8 or 16.
REQ-003 Parameter STOP_BITS, default 1, number of stop bits checked; legal values 1 or 2.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 os_tick  input  1  one-clk strobe at OS_RATE x baud rate.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 parity_en  input  1  1 = parity bit follows data bits; sampled at start-bit confirmation.
REQ-009 parity_odd  input  1  1 = odd parity, 0 = even; sampled with parity_en.
REQ-010 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-011 rx_data  output  DATA_BITS  last good received word, LSB received first.
REQ-012 rx_valid  output  1  level; high while rx_data holds an unacknowledged word.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-015 parity_err  output  1  one-clk pulse, parity mismatch.
REQ-016 overrun  output  1  sticky; set when a good frame completes while rx_valid is high.

Function
REQ-017 rx SHALL pass through a 2-flop synchronizer (reset value 1); all sampling uses the synchronized value rx_s.
REQ-018 State machine states SHALL be IDLE, START, DATA, PARITY, STOP; tick counter counts os_tick only, never raw clk.
REQ-019 IDLE: on os_tick with rx_s=0, go to START and clear tick counter.
REQ-020 START: at the os_tick where counter reaches OS_RATE/2-1, if rx_s=0 go to DATA (counter and bit index cleared, parity mode latched); if rx_s=1 return to IDLE with no flags (glitch rejection).
REQ-021 DATA: every OS_RATE ticks sample rx_s into shift register LSB-first; after DATA_BITS samples go to PARITY if latched parity_en=1, else STOP.
REQ-022 PARITY: after OS_RATE ticks sample parity bit; expected value = XOR of data bits XOR latched parity_odd; go to STOP.
REQ-023 STOP: sample STOP_BITS stop bits, each OS_RATE ticks apart; any low sample marks frame error; after last stop sample return to IDLE.
REQ-024 Frame completion occurs on the clk of the last stop sample; flags and data update on the following clk edge.
REQ-025 Good frame (no frame or parity error): rx_data <= shift register, rx_valid <= 1; if rx_valid was already 1 and not acked that same cycle, overrun <= 1 and rx_data is overwritten with the new word.
REQ-026 Bad frame: frame_err and/or parity_err pulse high one clk; rx_data and rx_valid unchanged.
REQ-027 rx_ack while rx_valid=1 clears rx_valid next clk; rx_ack with rx_valid=0 has no effect.
REQ-028 Simultaneous rx_ack and good-frame completion: rx_valid stays 1 with new data, overrun not set.
REQ-029 overrun SHALL clear only on reset.
REQ-030 parity_en/parity_odd changes mid-frame SHALL not affect the frame in progress.
REQ-031 A line held low after a frame error SHALL not start a new frame until rx_s has been seen high in IDLE.

Reset
REQ-032 reset SHALL take effect on the clk edge it is sampled high, overriding all other inputs, including mid-frame.
REQ-033 Reset values: state IDLE, counters 0, shift register 0, synchronizer 1, rx_data 0, rx_valid 0, busy 0, frame_err 0, parity_err 0, overrun 0.
REQ-034 A frame interrupted by reset SHALL be discarded with no flags asserted.

Verification
REQ-035 Defaults, parity off, send 0xA5 8N1 -> rx_data=0xA5, rx_valid=1, no error pulses, busy low after stop sample.
REQ-036 rx low for 3 os_ticks then high -> returns to IDLE, busy drops, rx_valid stays 0, no flags.
REQ-037 parity_en=1, parity_odd=0, send 0x07 with parity bit 0 -> parity_err pulses once, rx_valid stays 0; same frame with parity bit 1 -> rx_data=0x07.
REQ-038 Send 0x3C with stop bit 0 -> frame_err one-clk pulse, rx_data unchanged; line returned high -> next frame 0x55 received correctly.
REQ-039 Send 0x11 then 0x22 without rx_ack -> rx_data=0x22, overrun=1 until reset; repeat with rx_ack on completion cycle -> overrun stays 0.
REQ-040 DATA_BITS=7, STOP_BITS=2, OS_RATE=8, send 0x5A with second stop bit 0 -> frame_err pulse; reset asserted mid-DATA of next frame -> all outputs at reset values, no flags.
